// File: rtl/dds_wavetable_scheduler.sv
// Time-division scheduler sharing one synchronous wavetable ROM among NCH DDS channels.
// Reconfiguration is staged in a single pending slot and committed only at frame boundaries.
module dds_wavetable_scheduler #(
    parameter int NCH     = 4,
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [$clog2(NCH)-1:0]   cfg_ch,
    input  logic [PHASE_W-1:0]       cfg_ftw,
    input  logic                     cfg_en,
    input  logic                     cfg_phase_clr,
    output logic [ADDR_W-1:0]        rom_raddr,
    input  logic [DATA_W-1:0]        rom_dout,
    output logic                     sample_valid,
    output logic [$clog2(NCH)-1:0]   sample_ch,
    output logic [DATA_W-1:0]        sample_data,
    output logic                     frame_done
);
    localparam int CH_W = $clog2(NCH);

    typedef enum logic {STOP, RUN} state_t;

    state_t              state, state_next;
    logic [CH_W-1:0]     slot;
    logic [PHASE_W-1:0]  phase [NCH];
    logic [PHASE_W-1:0]  ftw [NCH];
    logic [NCH-1:0]      en;

    logic                pend_valid;
    logic [CH_W-1:0]     pend_ch;
    logic [PHASE_W-1:0]  pend_ftw;
    logic                pend_en;
    logic                pend_clr;

    logic                stage1_en, stage2_en;
    logic [CH_W-1:0]     stage1_ch, stage2_ch;

    logic                issue;
    logic                last_slot;
    logic                commit;
    logic                xfer;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            STOP: begin
                if (run) state_next = RUN;
            end
            RUN: begin
                issue = 1'b1;
                if (last_slot && !run) state_next = STOP;
            end
            default: state_next = STOP;
        endcase
    end

    assign last_slot = (slot == CH_W'(NCH - 1));
    assign commit    = pend_valid && ((state == STOP) || (issue && last_slot));
    assign cfg_ready = ~pend_valid;
    assign xfer      = cfg_valid && cfg_ready;

    // Issue stage plus the two-stage tag pipeline that tracks the ROM's read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= STOP;
            slot         <= '0;
            frame_done   <= 1'b0;
            rom_raddr    <= '0;
            stage1_en    <= 1'b0;
            stage1_ch    <= '0;
            stage2_en    <= 1'b0;
            stage2_ch    <= '0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            sample_data  <= '0;
        end else begin
            state      <= state_next;
            frame_done <= issue && last_slot;
            stage1_en  <= 1'b0;
            if (issue) begin
                rom_raddr <= phase[slot][PHASE_W-1 -: ADDR_W];
                stage1_en <= en[slot];
                stage1_ch <= slot;
                slot      <= slot + CH_W'(1);
            end
            stage2_en    <= stage1_en;
            stage2_ch    <= stage1_ch;
            sample_valid <= stage2_en;
            if (stage2_en) begin
                sample_data <= rom_dout;
                sample_ch   <= stage2_ch;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_ch    <= '0;
            pend_ftw   <= '0;
            pend_en    <= 1'b0;
            pend_clr   <= 1'b0;
        end else if (xfer) begin
            pend_valid <= 1'b1;
            pend_ch    <= cfg_ch;
            pend_ftw   <= cfg_ftw;
            pend_en    <= cfg_en;
            pend_clr   <= cfg_phase_clr;
        end else if (commit) begin
            pend_valid <= 1'b0;
        end
    end

    // A commit lands after the slot's own accumulate, so a phase clear wins over the add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en <= '0;
            for (int i = 0; i < NCH; i++) begin
                phase[i] <= '0;
                ftw[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (issue && (slot == CH_W'(i)) && en[i])
                    phase[i] <= phase[i] + ftw[i];
                if (commit && (pend_ch == CH_W'(i))) begin
                    ftw[i] <= pend_ftw;
                    en[i]  <= pend_en;
                    if (pend_clr) phase[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dds_wavetable_scheduler.sv
// Directed scoreboard bench for dds_wavetable_scheduler with a behavioural ROM whose
// contents are a known function of the address.
module tb_dds_wavetable_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_ch = '0;
    logic [31:0] cfg_ftw = '0;
    logic        cfg_en = 1'b0;
    logic        cfg_phase_clr = 1'b0;
    logic [11:0] rom_raddr;
    logic [23:0] rom_dout = '0;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic [23:0] sample_data;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [1:0]  ch;
        logic [23:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];

    dds_wavetable_scheduler #(
        .NCH(4), .PHASE_W(32), .ADDR_W(12), .DATA_W(24)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_ftw(cfg_ftw),
        .cfg_en(cfg_en),
        .cfg_phase_clr(cfg_phase_clr),
        .rom_raddr(rom_raddr),
        .rom_dout(rom_dout),
        .sample_valid(sample_valid),
        .sample_ch(sample_ch),
        .sample_data(sample_data),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] rom_fn(input logic [11:0] a);
        return {a, a ^ 12'hA5C};
    endfunction

    always @(posedge clk) rom_dout <= rom_fn(rom_raddr);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ch, input logic [31:0] ftw,
                                 input logic en, input logic clr);
        cfg_ch        = ch;
        cfg_ftw       = ftw;
        cfg_en        = en;
        cfg_phase_clr = clr;
        cfg_valid     = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issueTick(input int s, input logic [11:0] a, input logic e);
        tick();
        checkOutput($sformatf("raddr_slot%0d", s), 32'(rom_raddr), 32'(a));
        checkOutput($sformatf("frame_done_slot%0d", s), 32'(frame_done), (s == 3) ? 32'd1 : 32'd0);
        if (e) sb.push_back('{ch: 2'(s), data: rom_fn(a), due: cyc + 2});
    endtask

    task automatic doFrame(input logic [11:0] a0, input logic [11:0] a1,
                           input logic [11:0] a2, input logic [11:0] a3, input logic [3:0] m);
        issueTick(0, a0, m[0]);
        issueTick(1, a1, m[1]);
        issueTick(2, a2, m[2]);
        issueTick(3, a3, m[3]);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_raddr"}, 32'(rom_raddr), 32'd0);
        checkOutput({tag, "_valid"}, 32'(sample_valid), 32'd0);
        checkOutput({tag, "_ch"}, 32'(sample_ch), 32'd0);
        checkOutput({tag, "_data"}, 32'(sample_data), 32'd0);
        checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        checkOutput({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    endtask

    // Every emitted sample must match the oldest expectation in channel, data and exact cycle.
    always @(negedge clk) begin
        if (!rst && sample_valid) begin
            checkOutput("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_ch", 32'(sample_ch), 32'(e.ch));
                checkOutput("sb_data", 32'(sample_data), 32'(e.data));
                checkOutput("sb_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset_held");
        @(negedge clk) rst = 1'b0;
        tick();
        checkAllZero("reset_released");

        // ch0 configured while stopped: commit on the edge after the transfer.
        applyStimulus(2'd0, 32'h0010_0000, 1'b1, 1'b1);
        tick();
        cfg_valid = 1'b0;
        checkOutput("stop_cfg_ready_low", 32'(cfg_ready), 32'd0);
        tick();
        checkOutput("stop_cfg_ready_high", 32'(cfg_ready), 32'd1);

        run = 1'b1;
        tick();
        for (int f = 0; f < 3; f++) doFrame(12'(f), 12'h000, 12'h000, 12'h000, 4'b0001);

        // ch1 half-scale step, committed at the end of frame 3.
        applyStimulus(2'd1, 32'h8000_0000, 1'b1, 1'b1);
        issueTick(0, 12'd3, 1'b1);
        cfg_valid = 1'b0;
        checkOutput("f3_cfg_ready_low", 32'(cfg_ready), 32'd0);
        issueTick(1, 12'h000, 1'b0);
        issueTick(2, 12'h000, 1'b0);
        checkOutput("f3_cfg_ready_still_low", 32'(cfg_ready), 32'd0);
        issueTick(3, 12'h000, 1'b0);
        checkOutput("f3_cfg_ready_after_commit", 32'(cfg_ready), 32'd1);

        applyStimulus(2'd3, 32'hFFF0_0000, 1'b1, 1'b1);
        issueTick(0, 12'd4, 1'b1);
        cfg_valid = 1'b0;
        issueTick(1, 12'h000, 1'b1);
        issueTick(2, 12'h000, 1'b0);
        issueTick(3, 12'h000, 1'b0);

        // ch3 new FTW commits after its own add in this frame, so the next step wraps to 0.
        applyStimulus(2'd3, 32'h0010_0000, 1'b1, 1'b0);
        issueTick(0, 12'd5, 1'b1);
        cfg_valid = 1'b0;
        issueTick(1, 12'h800, 1'b1);
        issueTick(2, 12'h000, 1'b0);
        issueTick(3, 12'h000, 1'b1);

        doFrame(12'd6, 12'h000, 12'h000, 12'hFFF, 4'b1011);
        doFrame(12'd7, 12'h800, 12'h000, 12'h000, 4'b1011);
        doFrame(12'd8, 12'h000, 12'h000, 12'h001, 4'b1011);

        // Mid-frame ch2 write, then a second request held while the slot is busy.
        issueTick(0, 12'd9, 1'b1);
        applyStimulus(2'd2, 32'h0020_0000, 1'b1, 1'b0);
        issueTick(1, 12'h800, 1'b1);
        applyStimulus(2'd2, 32'h0050_0000, 1'b1, 1'b0);
        checkOutput("f9_cfg_ready_low_s1", 32'(cfg_ready), 32'd0);
        issueTick(2, 12'h000, 1'b0);
        checkOutput("f9_cfg_ready_low_s2", 32'(cfg_ready), 32'd0);
        issueTick(3, 12'h002, 1'b1);
        cfg_valid = 1'b0;
        checkOutput("f9_cfg_ready_commit", 32'(cfg_ready), 32'd1);

        doFrame(12'd10, 12'h000, 12'h000, 12'h003, 4'b1111);
        doFrame(12'd11, 12'h800, 12'h002, 12'h004, 4'b1111);

        // Drop run at slot 1: the frame completes, then exactly two samples drain.
        issueTick(0, 12'd12, 1'b1);
        issueTick(1, 12'h000, 1'b1);
        run = 1'b0;
        issueTick(2, 12'h004, 1'b1);
        issueTick(3, 12'h005, 1'b1);
        tick();
        checkOutput("stop_drain1_valid", 32'(sample_valid), 32'd1);
        checkOutput("stop_frame_done_once", 32'(frame_done), 32'd0);
        checkOutput("stop_raddr_hold", 32'(rom_raddr), 32'h005);
        tick();
        checkOutput("stop_drain2_valid", 32'(sample_valid), 32'd1);
        tick();
        checkOutput("stop_drained_valid", 32'(sample_valid), 32'd0);
        checkOutput("stop_sb_empty", 32'(sb.size()), 32'd0);
        tick();
        checkOutput("stop_no_issue", 32'(rom_raddr), 32'h005);
        checkOutput("stop_idle_valid", 32'(sample_valid), 32'd0);

        // Asynchronous reset while running with a pending config and samples in flight.
        run = 1'b1;
        tick();
        issueTick(0, 12'd13, 1'b1);
        applyStimulus(2'd1, 32'h0030_0000, 1'b1, 1'b1);
        issueTick(1, 12'h800, 1'b1);
        cfg_valid = 1'b0;
        checkOutput("rst_pending_ready_low", 32'(cfg_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        checkAllZero("async_reset");
        sb.delete();
        @(negedge clk);
        tick();
        checkAllZero("reset_hold_edge");
        @(negedge clk) rst = 1'b0;
        tick();
        doFrame(12'h000, 12'h000, 12'h000, 12'h000, 4'b0000);
        doFrame(12'h000, 12'h000, 12'h000, 12'h000, 4'b0000);
        tick();
        checkOutput("post_reset_valid", 32'(sample_valid), 32'd0);
        checkOutput("post_reset_cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
